// File: rtl/fftframe_stream.sv
// fftframe_stream: turns the free-running bit-reversed FFT output into a ready/valid
// frame stream, dropping frames that do not fit and closing cut-short frames with an abort marker.
module fftframe_stream #(
    parameter int LGSIZE = 5,
    parameter int WIDTH  = 24,
    parameter int LGFIFO = 4
) (
    input  logic                 i_clk,
    input  logic                 i_areset_n,
    input  logic                 i_ce,
    input  logic [2*WIDTH-1:0]   i_in,
    input  logic                 i_sync,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [2*WIDTH-1:0]   o_data,
    output logic                 o_first,
    output logic                 o_last,
    output logic                 o_abort,
    output logic                 o_overflow,
    output logic [LGFIFO:0]      o_fill
);
    localparam int N  = 1 << LGSIZE;
    localparam int D  = 1 << LGFIFO;
    localparam int IW = (LGSIZE > 0) ? LGSIZE : 1;
    localparam int EW = 2*WIDTH + 3;
    localparam logic [IW-1:0]   IDX_LAST = IW'(N-1);
    localparam logic [LGFIFO:0] DATA_LIM = (LGFIFO+1)'(D-1);
    localparam logic [LGFIFO:0] FULL     = (LGFIFO+1)'(D);
    localparam logic            SINGLE   = (LGSIZE == 0);

    typedef enum logic [1:0] {SEEK, PASS, DROP} state_t;

    state_t            state, state_n;
    logic [IW-1:0]     idx, idx_n;
    logic [EW-1:0]     mem [D];
    logic [EW-1:0]     entry;
    logic [LGFIFO-1:0] wr_ptr, rd_ptr;
    logic              push, pop, ovf, space, marker_ok, last_idx;

    // the last FIFO slot is kept free so a marker can always close a partial frame
    assign space     = o_fill < DATA_LIM;
    assign marker_ok = o_fill < FULL;
    assign last_idx  = idx == IDX_LAST;
    assign o_valid   = o_fill != '0;
    assign pop       = o_valid && i_ready;
    assign {o_abort, o_last, o_first, o_data} = o_valid ? mem[rd_ptr] : '0;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        push    = 1'b0;
        entry   = '0;
        ovf     = 1'b0;
        if (i_ce) begin
            if (state == PASS) begin
                if (!i_sync && space) begin
                    push    = 1'b1;
                    entry   = {1'b0, last_idx, 1'b0, i_in};
                    idx_n   = last_idx ? '0 : idx + 1'b1;
                    state_n = last_idx ? SEEK : PASS;
                end else begin
                    push    = marker_ok;
                    entry   = {2'b11, 1'b0, {2*WIDTH{1'b0}}};
                    ovf     = 1'b1;
                    idx_n   = '0;
                    state_n = DROP;
                end
            end else if (i_sync) begin
                if (space) begin
                    push    = 1'b1;
                    entry   = {1'b0, SINGLE, 1'b1, i_in};
                    idx_n   = SINGLE ? '0 : IW'(1);
                    state_n = SINGLE ? SEEK : PASS;
                end else begin
                    ovf     = 1'b1;
                    state_n = SEEK;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state      <= SEEK;
            idx        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_fill     <= '0;
            o_overflow <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            o_overflow <= ovf;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            o_fill <= o_fill + (LGFIFO+1)'(push) - (LGFIFO+1)'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= entry;
    end
endmodule
